cpu_issue_scoreboard: RTL
=========================

CPU_ISSUE_SCOREBOARD -- requirements
Module: cpu_issue_scoreboard

Interface
REQ-001 SHALL have port: i_clock  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: i_reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: i_valid  in  1  decoded instruction present at issue.
REQ-004 SHALL have ports: i_rs1, i_rs2, i_rs3, i_rd  in  6 each  {bank, index}; bank 1 = FP file.
REQ-005 SHALL have ports: i_have_rs1, i_have_rs2, i_have_rs3, i_have_rd  in  1 each  operand-used flags.
REQ-006 SHALL have ports: i_complex, i_fpu  in  1 each  instruction needs the complex unit or the FPU.
REQ-007 SHALL have port: o_ready  out  1  instruction may issue this cycle.
REQ-008 SHALL have port: o_fire  out  1  i_valid & o_ready.
REQ-009 SHALL have ports: i_wb_valid, i_wb_rd  in  1, 6  writeback retires one destination.
REQ-010 SHALL have ports: i_complex_done, i_fpu_done  in  1 each  unit finished its operation.
REQ-011 SHALL have port: i_flush  in  1  discard all in-flight tracking (trap/branch redirect).
REQ-012 SHALL have port: o_busy  out  64  per-register pending bitmap.
REQ-013 SHALL have port: o_stall_count  out  32  saturating count of cycles with i_valid & !o_ready.

Function
REQ-014 Register 6'h00 (integer x0) SHALL never be marked busy and SHALL never cause a stall.
REQ-015 o_ready SHALL be combinational: deasserted if any used source is busy (RAW), the used rd is busy (WAW), i_complex while the complex unit is busy, or i_fpu while the FPU is busy; otherwise asserted.
REQ-016 A writeback in the same cycle SHALL clear that register's busy state for the REQ-015 evaluation (bypass); i_complex_done/i_fpu_done SHALL likewise free their unit in the same cycle.
REQ-017 On o_fire with i_have_rd and rd != 0, busy[rd] SHALL be set at the next edge.
REQ-018 On o_fire with i_complex (resp. i_fpu), the complex-unit (resp. FPU) busy flag SHALL be set at the next edge.
REQ-019 On i_wb_valid, busy[i_wb_rd] SHALL be cleared at the next edge; when a set (REQ-017) and a clear target the same register in one cycle, the set SHALL win.
REQ-020 A done pulse and a new issue to the same unit in one cycle SHALL leave the unit busy.
REQ-021 A writeback to a non-busy register or a done pulse for an idle unit SHALL be ignored without error.
REQ-022 i_flush SHALL clear all busy bits and both unit flags at the next edge, force o_ready low in the flush cycle, and take priority over issue, writeback and done in that cycle.
REQ-023 o_stall_count SHALL increment by 1 per stall cycle, SHALL saturate at 32'hFFFFFFFF, and SHALL not be cleared by i_flush.
REQ-024 Issue-to-busy latency SHALL be 1 cycle; there SHALL be no combinational path from i_wb_* to o_busy.

Reset
REQ-025 On i_reset, o_busy SHALL be 0, both unit flags 0, and o_stall_count 0; o_ready SHALL be 0 during the reset cycle.
REQ-026 Reset SHALL take priority over flush, issue and writeback.

Structure
REQ-027 The register-tag width (6), the bank-bit position, and the register count (64) SHALL be constants in the shared CPU package.
REQ-028 The hazard check SHALL be a sub-module cpu_hazard_check (combinational sources/rd vs. busy bitmap with bypass); the scoreboard state SHALL stay in the top module.

Verification
REQ-029 Issue ADD rd=6'h05; next cycle issue rs1=6'h05 -> o_ready=0 until i_wb_valid with rd=6'h05, then o_ready=1 in that writeback cycle.
REQ-030 Issue rd=6'h00, then rs1=6'h00 -> no stall; o_busy stays 0.
REQ-031 Issue DIV (i_complex=1); issue MUL next -> stall; pulse i_complex_done -> MUL fires the same cycle; complex flag remains 1.
REQ-032 Same-cycle issue rd=6'h23 and i_wb_rd=6'h23 -> o_busy[35]=1 after the edge.
REQ-033 Set busy on 6'h01, 6'h21 and the FPU flag, assert i_flush -> o_busy=0 and FPU free at the next edge; o_stall_count unchanged.
REQ-034 Hold a RAW stall for 10 cycles from reset -> o_stall_count=10; preload near saturation -> count holds at 32'hFFFFFFFF.

Source files
------------

// File: rtl/cpu_issue_scoreboard_pkg.sv
// Shared CPU constants and types for the issue scoreboard: register-tag layout,
// register-file size and the per-unit busy flags.
package cpu_issue_scoreboard_pkg;
  localparam int TAG_W    = 6;
  localparam int BANK_BIT = 5;   // tag[BANK_BIT] = 1 selects the FP register file
  localparam int NUM_REGS = 64;
  localparam int STALL_W  = 32;

  typedef logic [TAG_W-1:0]    reg_tag_t;
  typedef logic [NUM_REGS-1:0] busy_map_t;

  typedef struct packed {
    logic complex_busy;
    logic fpu_busy;
  } unit_flags_t;

  // Integer x0 is hardwired zero and is never tracked.
  function automatic logic is_x0(input reg_tag_t tag);
    return tag == '0;
  endfunction
endpackage

// File: rtl/cpu_issue_scoreboard_if.sv
// Issue, writeback and status signals of the issue scoreboard.
interface cpu_issue_scoreboard_if;
  import cpu_issue_scoreboard_pkg::*;

  // Handshake: an instruction issues (o_fire) in any cycle where i_valid and
  // o_ready are both high; o_ready never depends on i_valid, and a stalled
  // instruction is simply re-presented by the decoder until it fires.
  logic                 i_valid;
  reg_tag_t             i_rs1, i_rs2, i_rs3, i_rd;
  logic                 i_have_rs1, i_have_rs2, i_have_rs3, i_have_rd;
  logic                 i_complex, i_fpu;
  logic                 o_ready, o_fire;
  logic                 i_wb_valid;
  reg_tag_t             i_wb_rd;
  logic                 i_complex_done, i_fpu_done;
  logic                 i_flush;
  busy_map_t            o_busy;
  logic [STALL_W-1:0]   o_stall_count;
  logic                 i_stall_load;
  logic [STALL_W-1:0]   i_stall_load_value;

  modport master (
    output i_valid, i_rs1, i_rs2, i_rs3, i_rd,
    output i_have_rs1, i_have_rs2, i_have_rs3, i_have_rd,
    output i_complex, i_fpu, i_wb_valid, i_wb_rd,
    output i_complex_done, i_fpu_done, i_flush,
    output i_stall_load, i_stall_load_value,
    input  o_ready, o_fire, o_busy, o_stall_count
  );

  modport slave (
    input  i_valid, i_rs1, i_rs2, i_rs3, i_rd,
    input  i_have_rs1, i_have_rs2, i_have_rs3, i_have_rd,
    input  i_complex, i_fpu, i_wb_valid, i_wb_rd,
    input  i_complex_done, i_fpu_done, i_flush,
    input  i_stall_load, i_stall_load_value,
    output o_ready, o_fire, o_busy, o_stall_count
  );
endinterface

// File: rtl/cpu_issue_scoreboard_hazard_check.sv
// Combinational RAW/WAW check of the issuing instruction against the busy
// bitmap, with same-cycle writeback bypass.
module cpu_hazard_check
  import cpu_issue_scoreboard_pkg::*;
(
  input  busy_map_t busy,
  input  logic      wb_valid,
  input  reg_tag_t  wb_rd,
  input  reg_tag_t  rs1,
  input  reg_tag_t  rs2,
  input  reg_tag_t  rs3,
  input  reg_tag_t  rd,
  input  logic      have_rs1,
  input  logic      have_rs2,
  input  logic      have_rs3,
  input  logic      have_rd,
  output logic      hazard
);
  busy_map_t eff_busy;

  always_comb begin
    eff_busy = busy;
    if (wb_valid) eff_busy[wb_rd] = 1'b0;
    eff_busy[0] = 1'b0;
    hazard = (have_rs1 && eff_busy[rs1]) ||
             (have_rs2 && eff_busy[rs2]) ||
             (have_rs3 && eff_busy[rs3]) ||
             (have_rd  && eff_busy[rd]);
  end
endmodule

// File: rtl/cpu_issue_scoreboard.sv
// In-order issue scoreboard: per-register pending bits, complex-unit and FPU
// busy flags, issue gating and a saturating stall-cycle counter.
module cpu_issue_scoreboard
  import cpu_issue_scoreboard_pkg::*;
(
  input logic                   i_clock,
  input logic                   i_reset,
  cpu_issue_scoreboard_if.slave sb
);
  busy_map_t          busy_q, busy_d;
  unit_flags_t        unit_q, unit_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               reg_hazard, complex_free, fpu_free, ready, fire, stall;

  cpu_hazard_check u_hazard (
    .busy     (busy_q),
    .wb_valid (sb.i_wb_valid),
    .wb_rd    (sb.i_wb_rd),
    .rs1      (sb.i_rs1),
    .rs2      (sb.i_rs2),
    .rs3      (sb.i_rs3),
    .rd       (sb.i_rd),
    .have_rs1 (sb.i_have_rs1),
    .have_rs2 (sb.i_have_rs2),
    .have_rs3 (sb.i_have_rs3),
    .have_rd  (sb.i_have_rd),
    .hazard   (reg_hazard)
  );

  // A done pulse frees its unit for this cycle's issue decision.
  assign complex_free = !unit_q.complex_busy || sb.i_complex_done;
  assign fpu_free     = !unit_q.fpu_busy     || sb.i_fpu_done;

  assign ready = !i_reset && !sb.i_flush && !reg_hazard &&
                 (!sb.i_complex || complex_free) &&
                 (!sb.i_fpu     || fpu_free);
  assign fire  = sb.i_valid && ready;
  assign stall = sb.i_valid && !ready;

  always_comb begin
    busy_d  = busy_q;
    unit_d  = unit_q;
    stall_d = stall_q;
    if (sb.i_flush) begin
      busy_d = '0;
      unit_d = '0;
    end else begin
      // Clear before set so an issue wins over a same-cycle writeback.
      if (sb.i_wb_valid) busy_d[sb.i_wb_rd] = 1'b0;
      if (fire && sb.i_have_rd && !is_x0(sb.i_rd)) busy_d[sb.i_rd] = 1'b1;
      if (sb.i_complex_done) unit_d.complex_busy = 1'b0;
      if (sb.i_fpu_done)     unit_d.fpu_busy     = 1'b0;
      if (fire && sb.i_complex) unit_d.complex_busy = 1'b1;
      if (fire && sb.i_fpu)     unit_d.fpu_busy     = 1'b1;
    end
    if (sb.i_stall_load) stall_d = sb.i_stall_load_value;
    else if (stall && stall_q != '1) stall_d = stall_q + STALL_W'(1);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      busy_q  <= '0;
      unit_q  <= '0;
      stall_q <= '0;
    end else begin
      busy_q  <= busy_d;
      unit_q  <= unit_d;
      stall_q <= stall_d;
    end
  end

  assign sb.o_ready       = ready;
  assign sb.o_fire        = fire;
  assign sb.o_busy        = busy_q;
  assign sb.o_stall_count = stall_q;
endmodule
